// File: rtl/stdin_arb.sv
// stdin_arb: two-requester round-robin arbiter in front of a stdin word source.
// Each accepted request runs IDLE -> READ -> RESP: grant in READ (with a
// read-advance strobe to the source unless EOF), response in RESP.
// Optional feature macro: STDIN_ARB_STATS_EN adds rd_cnt0_o / rd_cnt1_o,
// per-requester 16-bit response counters that wrap.
// Handshake: a requester raises its req_i bit and holds it until its rvalid_o
// bit pulses; gnt_o pulses one cycle in READ, rvalid_o one cycle in RESP, and
// rdata_o is meaningful only while rvalid_o is non-zero. Requests are sampled
// only in IDLE; dropping req_i afterwards does not cancel the transaction.
module stdin_arb #(
    parameter int NUM_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [1:0]  req_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  rvalid_o,
    output logic [31:0] rdata_o,
    output logic        eof_o,
    output logic        stdin_read_o,
    input  logic [31:0] stdin_din_i,
`ifdef STDIN_ARB_STATS_EN
    output logic [15:0] rd_cnt0_o,
    output logic [15:0] rd_cnt1_o,
`endif
    output logic [1:0]  state_o
);

    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       winner;    // one-hot owner of the in-flight transaction
    logic             last_gnt;  // index of the requester granted most recently
    logic [CNT_W-1:0] consumed;
    logic [1:0]       pick;

    assign state_o = state;

    // Round-robin choice: a lone requester wins, on a tie the one not granted last wins.
    always_comb begin
        pick = 2'b00;
        case (req_i)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_gnt ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

    // Transaction FSM with registered grant/strobe/response outputs and EOF tracking.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state        <= IDLE;
            winner       <= 2'b00;
            last_gnt     <= 1'b1;
            consumed     <= '0;
            gnt_o        <= 2'b00;
            rvalid_o     <= 2'b00;
            rdata_o      <= 32'h0;
            eof_o        <= 1'b0;
            stdin_read_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rvalid_o <= 2'b00;
                    if (req_i != 2'b00) begin
                        state        <= READ;
                        winner       <= pick;
                        gnt_o        <= pick;
                        last_gnt     <= pick[1];
                        stdin_read_o <= ~eof_o;
                    end
                end
                READ: begin
                    gnt_o        <= 2'b00;
                    stdin_read_o <= 1'b0;
                    rvalid_o     <= winner;
                    state        <= RESP;
                    if (stdin_read_o) begin
                        rdata_o <= stdin_din_i;
                        if (consumed != CNT_W'(NUM_WORDS)) begin
                            consumed <= consumed + CNT_W'(1);
                        end
                        if (consumed + CNT_W'(1) == CNT_W'(NUM_WORDS)) begin
                            eof_o <= 1'b1;
                        end
                    end else begin
                        // Past EOF the source is not advanced and the requester gets zero.
                        rdata_o <= 32'h0;
                    end
                end
                RESP: begin
                    rvalid_o <= 2'b00;
                    state    <= IDLE;
                end
                default: begin
                    gnt_o        <= 2'b00;
                    rvalid_o     <= 2'b00;
                    stdin_read_o <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef STDIN_ARB_STATS_EN
    // Count response cycles per requester; the 16-bit wrap is intentional.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_cnt0_o <= 16'h0;
            rd_cnt1_o <= 16'h0;
        end else if (state == RESP) begin
            if (winner[0]) rd_cnt0_o <= rd_cnt0_o + 16'd1;
            if (winner[1]) rd_cnt1_o <= rd_cnt1_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stdin_arb.sv
// tb_stdin_arb: randomized and directed traffic against a transaction-level
// model of the arbiter; a monitor pops expected grants/responses from queues.
module tb_stdin_arb;

    localparam int NW = 4;
    localparam int NEVER = 32'h7fffffff;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic reset_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [1:0]  req_i = 2'b00;
    logic [1:0]  gnt_o, rvalid_o, state_dbg;
    logic [31:0] rdata_o, stdin_din_i;
    logic        eof_o, stdin_read_o;
`ifdef STDIN_ARB_STATS_EN
    logic [15:0] rd_cnt0_o, rd_cnt1_o;
`endif

    stdin_arb #(.NUM_WORDS(NW)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .eof_o        (eof_o),
        .stdin_read_o (stdin_read_o),
        .stdin_din_i  (stdin_din_i),
`ifdef STDIN_ARB_STATS_EN
        .rd_cnt0_o    (rd_cnt0_o),
        .rd_cnt1_o    (rd_cnt1_o),
`endif
        .state_o      (state_dbg)
    );

    // ---------------- stdin source (bench-owned) ----------------
    logic [31:0] src_words [256];
    logic [7:0]  src_idx = 8'd0;
    assign stdin_din_i = src_words[src_idx];
    always @(posedge clk_i) if (stdin_read_o) src_idx <= src_idx + 8'd1;

    // ---------------- reference model state ----------------
    int          busy_until;     // first cycle the block is free to sample again
    int          m_consumed;
    int          m_last;         // index of last granted requester
    int          exp_eof_cycle;
    logic [7:0]  m_src;          // source words the model believes were consumed
    logic [1:0]  drop_next;
    logic [15:0] m_rd0, m_rd1;

    // {cycle, gnt, strobe} and {cycle, rvalid, data}
    logic [34:0] gnt_q[$];
    logic [65:0] exp_q[$];

    int n_vec = 0;
    int n_fail = 0;

    task automatic model_reset();
        m_consumed    = 0;
        m_last        = 1;
        exp_eof_cycle = NEVER;
        busy_until    = 0;
        drop_next     = 2'b00;
        m_rd0         = 16'h0;
        m_rd1         = 16'h0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [34:0] mon_g;
    logic [65:0] mon_e;
    logic        mon_eof;

    always @(negedge clk_i) begin
        if (!reset_i) begin
            n_vec++;
            if ({gnt_o, rvalid_o, stdin_read_o, eof_o, rdata_o, state_dbg} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got gnt=%b rvalid=%b strobe=%b eof=%b rdata=%h state=%0d, want all zero",
                         gnt_o, rvalid_o, stdin_read_o, eof_o, rdata_o, state_dbg);
            end
`ifdef STDIN_ARB_STATS_EN
            n_vec++;
            if ({rd_cnt0_o, rd_cnt1_o} !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_stats: got %h/%h want 0/0", rd_cnt0_o, rd_cnt1_o);
            end
`endif
        end else begin
            // grant channel
            if (gnt_q.size() > 0 && int'(gnt_q[0][34:3]) < cyc) begin
                n_vec++; n_fail++;
                mon_g = gnt_q.pop_front();
                $display("FAIL missed_gnt: cycle %0d no grant, want gnt=%b", cyc, mon_g[2:1]);
            end
            if (gnt_o != 2'b00) begin
                n_vec++;
                if (gnt_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_gnt: cycle %0d got gnt=%b, want none", cyc, gnt_o);
                end else begin
                    mon_g = gnt_q.pop_front();
                    if (mon_g !== {32'(cyc), gnt_o, stdin_read_o}) begin
                        n_fail++;
                        $display("FAIL gnt: cycle %0d got gnt=%b strobe=%b, want cycle %0d gnt=%b strobe=%b",
                                 cyc, gnt_o, stdin_read_o, mon_g[34:3], mon_g[2:1], mon_g[0]);
                    end
                end
            end else begin
                n_vec++;
                if (stdin_read_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stray_strobe: cycle %0d got strobe=%b without grant, want 0", cyc, stdin_read_o);
                end
            end
            // response channel
            if (exp_q.size() > 0 && int'(exp_q[0][65:34]) < cyc) begin
                n_vec++; n_fail++;
                mon_e = exp_q.pop_front();
                $display("FAIL missed_rvalid: cycle %0d no response, want rvalid=%b data=%h", cyc, mon_e[33:32], mon_e[31:0]);
            end
            if (rvalid_o != 2'b00) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rvalid: cycle %0d got rvalid=%b, want none", cyc, rvalid_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e !== {32'(cyc), rvalid_o, rdata_o}) begin
                        n_fail++;
                        $display("FAIL rvalid: cycle %0d got rvalid=%b rdata=%h, want cycle %0d rvalid=%b rdata=%h",
                                 cyc, rvalid_o, rdata_o, mon_e[65:34], mon_e[33:32], mon_e[31:0]);
                    end
                end
            end
            // eof flag
            n_vec++;
            mon_eof = (cyc >= exp_eof_cycle);
            if (eof_o !== mon_eof) begin
                n_fail++;
                $display("FAIL eof: cycle %0d got %b want %b", cyc, eof_o, mon_eof);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One cycle of requester behaviour plus the model's decision for that cycle.
    // mode 0: no new requests, 1: random, 2: both always requesting.
    task automatic step(input int mode, input logic [1:0] add_req, input logic early);
        logic [1:0]  dropped, win;
        logic        strobe;
        logic [31:0] data;
        int          pref, idx;
        @(posedge clk_i); #2;
        dropped   = rvalid_o | drop_next;
        drop_next = 2'b00;
        req_i     = req_i & ~dropped;
        for (int k = 0; k < 2; k++) begin
            if (!req_i[k] && !dropped[k]) begin
                if (mode == 1 && $urandom_range(0, 2) == 0) req_i[k] = 1'b1;
                if (mode == 2) req_i[k] = 1'b1;
            end
        end
        req_i = req_i | add_req;
        if (cyc >= busy_until && req_i != 2'b00) begin
            pref   = (m_last + 1) % 2;
            idx    = req_i[pref] ? pref : m_last;
            win    = (idx == 0) ? 2'b01 : 2'b10;
            m_last = idx;
            strobe = (m_consumed < NW);
            data   = strobe ? src_words[m_src] : 32'h0;
            if (strobe) begin
                m_src = m_src + 8'd1;
                m_consumed++;
                if (m_consumed == NW) exp_eof_cycle = cyc + 2;
            end
            gnt_q.push_back({32'(cyc + 1), win, strobe});
            exp_q.push_back({32'(cyc + 2), win, data});
            if (idx == 0) m_rd0 = m_rd0 + 16'd1;
            else          m_rd1 = m_rd1 + 16'd1;
            busy_until = cyc + 3;
            if (early) drop_next = win;
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i); #2;
        reset_i = 1'b0;
        req_i   = 2'b00;
        // A transaction still before its READ edge never advanced the source.
        for (int i = 0; i < gnt_q.size(); i++) if (gnt_q[i][0]) m_src = m_src - 8'd1;
        gnt_q.delete();
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk_i);
        #2;
        reset_i = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        n_vec++;
        if (gnt_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: got %0d grants/%0d responses outstanding, want 0/0", tag, gnt_q.size(), exp_q.size());
        end
`ifdef STDIN_ARB_STATS_EN
        n_vec++;
        if (rd_cnt0_o !== m_rd0 || rd_cnt1_o !== m_rd1) begin
            n_fail++;
            $display("FAIL stats_%s: got %0d/%0d want %0d/%0d", tag, rd_cnt0_o, rd_cnt1_o, m_rd0, m_rd1);
        end
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) src_words[i] = $urandom;
        src_words[0] = 32'hDEADBEEF;
        m_src = 8'd0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #2;
        reset_i = 1'b1;

        // single request from requester 0
        step(0, 2'b01, 1'b0);
        repeat (4) step(0, 2'b00, 1'b0);
        check_idle("single");

        // contention: both held for four transactions
        repeat (12) step(2, 2'b00, 1'b0);
        repeat (8) step(0, 2'b00, 1'b0);
        check_idle("contention");

        // EOF: six requests from requester 0 after a fresh reset
        do_reset();
        repeat (6) begin
            step(0, 2'b01, 1'b0);
            step(0, 2'b00, 1'b0);
            step(0, 2'b00, 1'b0);
        end
        repeat (4) step(0, 2'b00, 1'b0);
        check_idle("eof");

        // early drop after one IDLE cycle
        do_reset();
        step(0, 2'b01, 1'b1);
        repeat (5) step(0, 2'b00, 1'b0);
        check_idle("early_drop");

        // reset during READ, then requester 0 wins again
        step(0, 2'b10, 1'b0);
        repeat (4) step(0, 2'b00, 1'b0);
        step(0, 2'b11, 1'b0);
        do_reset();
        step(0, 2'b11, 1'b0);
        repeat (8) step(0, 2'b00, 1'b0);
        check_idle("mid_reset");

        // randomized rounds
        repeat (5) begin
            do_reset();
            repeat (60) step(1, 2'b00, 1'b0);
            repeat (10) step(0, 2'b00, 1'b0);
            check_idle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
